// File: rtl/seq_mul_pkg.sv
// Shared definitions for the iterative shift-add multiplier: state encoding,
// parameter legality check and CALC cycle count.
package seq_mul_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Width must be at least 2 and the per-cycle slice must tile it exactly.
  function automatic bit params_ok(input int nbits, input int bpc);
    return (nbits >= 2) && (bpc >= 1) && (bpc <= nbits) && ((nbits % bpc) == 0);
  endfunction

  function automatic int calc_cycles(input int nbits, input int bpc);
    return (bpc > 0) ? nbits / bpc : 1;
  endfunction

endpackage

// File: rtl/seq_mul_step.sv
// One shift-add step: folds BITS_PER_CYCLE multiplier bits into the
// accumulator and advances both operands.
module seq_mul_step
  import seq_mul_pkg::*;
#(
  parameter int NBITS          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [2*NBITS-1:0] a,
  input  logic [NBITS-1:0]   b,
  input  logic [2*NBITS-1:0] acc,
  output logic [2*NBITS-1:0] acc_next,
  output logic [2*NBITS-1:0] a_next,
  output logic [NBITS-1:0]   b_next
);

  logic [2*NBITS-1:0] pp;

  // NOTE: combinational logic uses blocking assignments, and pp gets a
  // default before the loop so no latch can be inferred.
  always_comb begin
    pp = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (b[i]) pp = pp + (a << i);
    end
  end

  assign acc_next = acc + pp;
  assign a_next   = a << BITS_PER_CYCLE;
  assign b_next   = b >> BITS_PER_CYCLE;

endmodule

// File: rtl/seq_mul_iterative.sv
// Iterative signed/unsigned multiplier with val/rdy streams; operands are
// reduced to magnitudes on entry and the sign is restored on the last step.
module seq_mul_iterative
  import seq_mul_pkg::*;
#(
  parameter int NBITS          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               istream_val,
  output logic               istream_rdy,
  input  logic [NBITS-1:0]   in0,
  input  logic [NBITS-1:0]   in1,
  input  logic               is_signed,
  output logic               ostream_val,
  input  logic               ostream_rdy,
  output logic [2*NBITS-1:0] out
);

  localparam int CYCLES = calc_cycles(NBITS, BITS_PER_CYCLE);
  localparam int CW     = $clog2(CYCLES + 1);

  if (!params_ok(NBITS, BITS_PER_CYCLE)) begin : g_param_check
    $fatal(1, "seq_mul_iterative: NBITS must be >= 2 and divisible by BITS_PER_CYCLE");
  end

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*NBITS-1:0] a_q, acc_q, out_q;
  logic [NBITS-1:0]   b_q;
  logic               neg_q;

  logic [2*NBITS-1:0] acc_next, a_next;
  logic [NBITS-1:0]   b_next;
  logic [NBITS-1:0]   mag0, mag1;

  // -2^(NBITS-1) negates to itself, which reads correctly as an unsigned magnitude.
  assign mag0 = (is_signed && in0[NBITS-1]) ? -in0 : in0;
  assign mag1 = (is_signed && in1[NBITS-1]) ? -in1 : in1;

  seq_mul_step #(
    .NBITS         (NBITS),
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .a       (a_q),
    .b       (b_q),
    .acc     (acc_q),
    .acc_next(acc_next),
    .a_next  (a_next),
    .b_next  (b_next)
  );

  // NOTE: state registers use non-blocking assignments; every register here
  // is plain flops, so all of them are cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      neg_q <= 1'b0;
      out_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (istream_val) begin
            neg_q <= is_signed & (in0[NBITS-1] ^ in1[NBITS-1]);
            a_q   <= {{NBITS{1'b0}}, mag0};
            b_q   <= mag1;
            acc_q <= '0;
            cnt   <= CW'(CYCLES);
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          acc_q <= acc_next;
          a_q   <= a_next;
          b_q   <= b_next;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            out_q <= neg_q ? -acc_next : acc_next;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (ostream_rdy) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Handshake flags come from the state register alone; reset also masks ready.
  assign istream_rdy = (state == ST_IDLE) && !reset;
  assign ostream_val = (state == ST_DONE);
  assign out         = out_q;

endmodule

// File: tb/tb_seq_mul_iterative.sv
// Self-checking bench for seq_mul_iterative: directed corner cases, reset
// abort, backpressure, alternate widths and a randomized regression.
module tb_seq_mul_iterative;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Default configuration: NBITS=8, BITS_PER_CYCLE=1.
  logic        iv, ir, sg, ov, ordy;
  logic [7:0]  a0, a1;
  logic [15:0] o;

  seq_mul_iterative #(.NBITS(8), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .reset(reset), .istream_val(iv), .istream_rdy(ir),
    .in0(a0), .in1(a1), .is_signed(sg),
    .ostream_val(ov), .ostream_rdy(ordy), .out(o)
  );

  // NBITS=8, BITS_PER_CYCLE=4.
  logic        iv4, ir4, sg4, ov4, ordy4;
  logic [7:0]  b0, b1;
  logic [15:0] o4;

  seq_mul_iterative #(.NBITS(8), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(reset), .istream_val(iv4), .istream_rdy(ir4),
    .in0(b0), .in1(b1), .is_signed(sg4),
    .ostream_val(ov4), .ostream_rdy(ordy4), .out(o4)
  );

  // NBITS=16, BITS_PER_CYCLE=2.
  logic        iv16, ir16, sg16, ov16, ordy16;
  logic [15:0] c0, c1;
  logic [31:0] o16;

  seq_mul_iterative #(.NBITS(16), .BITS_PER_CYCLE(2)) dut16 (
    .clk(clk), .reset(reset), .istream_val(iv16), .istream_rdy(ir16),
    .in0(c0), .in1(c1), .is_signed(sg16),
    .ostream_val(ov16), .ostream_rdy(ordy16), .out(o16)
  );

  // Reference: interpret operands as n-bit numbers, multiply, keep 2n bits.
  function automatic longint model(input int n, input longint x, input longint y, input bit s);
    longint p;
    if (s && x[n-1]) x = x - (longint'(1) << n);
    if (s && y[n-1]) y = y - (longint'(1) << n);
    p = x * y;
    return p & ((longint'(1) << (2 * n)) - 1);
  endfunction

  // One complete transaction on the default instance with full protocol checks.
  task automatic run_txn(input logic [7:0] x, input logic [7:0] y, input bit s,
                         input int stall, input bit flood);
    int          lat;
    bit          leak;
    logic [15:0] exp;
    exp = 16'(model(8, longint'(x), longint'(y), s));
    lat = 0;
    while (!ir && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (!ir) begin
      $display("FAIL rdy_timeout: istream_rdy=%b required 1", ir);
      bad++;
    end
    a0 = x; a1 = y; sg = s; iv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv = 1'b0; a0 = 8'($urandom); a1 = 8'($urandom); sg = 1'($urandom);
    lat = 0;
    leak = ir;
    while (!ov && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      leak = leak | ir;
    end
    total++;
    if (lat !== 8) begin
      $display("FAIL latency: got %0d cycles required 8 (%h*%h s=%b)", lat, x, y, s);
      bad++;
    end
    total++;
    if (leak) begin
      $display("FAIL rdy_during_txn: istream_rdy went 1 required 0");
      bad++;
    end
    total++;
    if (o !== exp) begin
      $display("FAIL product: %h*%h s=%b got %h required %h", x, y, s, o, exp);
      bad++;
    end
    for (int i = 0; i < stall; i++) begin
      if (flood) begin
        iv = 1'b1; a0 = 8'($urandom); a1 = 8'($urandom); sg = 1'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      total++;
      if (ov !== 1'b1 || o !== exp || ir !== 1'b0) begin
        $display("FAIL stall_hold: val=%b out=%h rdy=%b required val=1 out=%h rdy=0",
                 ov, o, ir, exp);
        bad++;
      end
    end
    iv = 1'b0;
    ordy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy = 1'b0;
    total++;
    if (ov !== 1'b0 || ir !== 1'b1 || o !== exp) begin
      $display("FAIL release: val=%b rdy=%b out=%h required val=0 rdy=1 out=%h",
               ov, ir, o, exp);
      bad++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    iv = 0; ordy = 0; sg = 0; a0 = 0; a1 = 0;
    iv4 = 0; ordy4 = 1; sg4 = 0; b0 = 0; b1 = 0;
    iv16 = 0; ordy16 = 1; sg16 = 0; c0 = 0; c1 = 0;
    #3;
    total++;
    if (ir !== 1'b0 || ov !== 1'b0 || o !== 16'h0) begin
      $display("FAIL reset_state: rdy=%b val=%b out=%h required 0 0 0000", ir, ov, o);
      bad++;
    end
    total++;
    if (ir4 !== 1'b0 || ir16 !== 1'b0 || ov4 !== 1'b0 || ov16 !== 1'b0) begin
      $display("FAIL reset_state_alt: rdy4=%b rdy16=%b val4=%b val16=%b required 0",
               ir4, ir16, ov4, ov16);
      bad++;
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (ir !== 1'b1) begin
      $display("FAIL post_reset_rdy: got %b required 1", ir);
      bad++;
    end
  endtask

  task automatic test_unsigned_max;
    run_txn(8'd255, 8'd255, 1'b0, 0, 1'b0);
    total++;
    if (o !== 16'hFE01) begin
      $display("FAIL unsigned_max: got %h required fe01", o);
      bad++;
    end
  endtask

  task automatic test_signed;
    run_txn(8'h80, 8'h80, 1'b1, 0, 1'b0);
    total++;
    if (o !== 16'h4000) begin
      $display("FAIL signed_min_sq: got %h required 4000", o);
      bad++;
    end
    run_txn(8'hFF, 8'h7F, 1'b1, 0, 1'b0);
    total++;
    if (o !== 16'hFF81) begin
      $display("FAIL signed_neg: got %h required ff81", o);
      bad++;
    end
    run_txn(8'hFF, 8'h7F, 1'b0, 0, 1'b0);
    total++;
    if (o !== 16'h7E81) begin
      $display("FAIL unsigned_mode: got %h required 7e81", o);
      bad++;
    end
  endtask

  task automatic test_backpressure;
    run_txn(8'd37, 8'd201, 1'b0, 5, 1'b1);
    run_txn(8'hC3, 8'h19, 1'b1, 0, 1'b0);
  endtask

  task automatic test_reset_mid_calc;
    bit spurious;
    @(negedge clk);
    a0 = 8'hAB; a1 = 8'hCD; sg = 1'b0; iv = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if (ir !== 1'b0 || ov !== 1'b0 || o !== 16'h0) begin
      $display("FAIL async_reset: rdy=%b val=%b out=%h required 0 0 0000", ir, ov, o);
      bad++;
    end
    @(negedge clk);
    iv = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    spurious = 1'b0;
    repeat (12) begin
      @(negedge clk);
      spurious = spurious | ov;
    end
    total++;
    if (spurious) begin
      $display("FAIL aborted_emit: ostream_val seen 1 required 0");
      bad++;
    end
    run_txn(8'd12, 8'd11, 1'b0, 0, 1'b0);
    total++;
    if (o !== 16'd132) begin
      $display("FAIL after_abort: got %0d required 132", o);
      bad++;
    end
  endtask

  task automatic test_configs;
    int          lat;
    logic [15:0] e4;
    logic [31:0] e16;
    for (int k = 0; k < 6; k++) begin
      b0 = (k == 0) ? 8'd200 : 8'($urandom);
      b1 = (k == 0) ? 8'd3 : 8'($urandom);
      sg4 = (k == 0) ? 1'b0 : 1'($urandom);
      e4 = 16'(model(8, longint'(b0), longint'(b1), sg4));
      lat = 0;
      while (!ir4 && lat < 20) begin @(negedge clk); lat++; end
      iv4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iv4 = 1'b0;
      lat = 0;
      while (!ov4 && lat < 20) begin @(posedge clk); @(negedge clk); lat++; end
      total++;
      if (lat !== 2 || o4 !== e4) begin
        $display("FAIL cfg8x4: lat=%0d out=%h required lat=2 out=%h", lat, o4, e4);
        bad++;
      end
      @(negedge clk);
    end
    total++;
    if (o4 === 16'hxxxx) begin
      $display("FAIL cfg8x4_x: out=%h required known", o4);
      bad++;
    end
    for (int k = 0; k < 6; k++) begin
      c0 = (k == 0) ? 16'hFFFF : 16'($urandom);
      c1 = (k == 0) ? 16'hFFFF : 16'($urandom);
      sg16 = (k == 0) ? 1'b0 : 1'($urandom);
      e16 = 32'(model(16, longint'(c0), longint'(c1), sg16));
      lat = 0;
      while (!ir16 && lat < 20) begin @(negedge clk); lat++; end
      iv16 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iv16 = 1'b0;
      lat = 0;
      while (!ov16 && lat < 40) begin @(posedge clk); @(negedge clk); lat++; end
      total++;
      if (lat !== 8 || o16 !== e16) begin
        $display("FAIL cfg16x2: lat=%0d out=%h required lat=8 out=%h", lat, o16, e16);
        bad++;
      end
      if (k == 0) begin
        total++;
        if (o16 !== 32'hFFFE0001) begin
          $display("FAIL cfg16x2_max: got %h required fffe0001", o16);
          bad++;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 1000; n++) begin
      run_txn(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset;
    test_unsigned_max;
    test_signed;
    test_backpressure;
    test_reset_mid_calc;
    test_configs;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete required finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_mul_iterative.md
Name: seq_mul_iterative

Overview:
Parametrised iterative multiplier. Takes two NBITS operands through a val/rdy input stream and returns a full 2*NBITS product through a val/rdy output stream. Processes BITS_PER_CYCLE multiplier bits per cycle using shift-add, and supports unsigned and signed (two's complement) modes selected per transaction. It is the area-saving, multi-cycle sibling of the single-cycle combinational multipliers, for datapaths that cannot afford an NBITS x NBITS array.

Parameters:
NBITS, 8, operand width; must be >= 2.
BITS_PER_CYCLE, 1, multiplier bits retired per CALC cycle; must divide NBITS evenly. Illegal values are rejected by an elaboration-time assertion.

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
istream_val  input  1  request valid
istream_rdy  output  1  block can accept a request
in0  input  NBITS  multiplicand
in1  input  NBITS  multiplier
is_signed  input  1  1 = treat in0/in1 as two's complement; 0 = unsigned
ostream_val  output  1  product valid
ostream_rdy  input  1  consumer accepts the product
out  output  2*NBITS  product

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high. While reset is high, all state is forced immediately: state=IDLE, counter=0, accumulator=0, out=0, ostream_val=0, istream_rdy=0. After reset deasserts, istream_rdy=1.
- States:
  - IDLE: istream_rdy=1, ostream_val=0.
  - CALC: istream_rdy=0, ostream_val=0.
  - DONE: istream_rdy=0, ostream_val=1.
- IDLE -> CALC on the edge where istream_val && istream_rdy. On that edge:
  - Latch neg = is_signed & (in0[NBITS-1] ^ in1[NBITS-1]).
  - Latch a = |in0| and b = |in1| when is_signed=1, otherwise the raw values. Magnitudes are NBITS-bit unsigned, so -2^(NBITS-1) maps to 2^(NBITS-1) with no overflow.
  - Clear acc (2*NBITS). Load counter = NBITS/BITS_PER_CYCLE.
- Each CALC cycle:
  - acc += a * b[BITS_PER_CYCLE-1:0], computed in 2*NBITS bits. a is held 2*NBITS wide.
  - a <<= BITS_PER_CYCLE; b >>= BITS_PER_CYCLE; counter -= 1.
  - No early termination. CALC lasts exactly NBITS/BITS_PER_CYCLE cycles regardless of operand values.
- Last CALC cycle (counter==1):
  - out <= neg ? -(acc_next) : acc_next, both modulo 2^(2*NBITS). acc_next is the accumulator value including this cycle's partial product.
  - Next state is DONE.
- DONE -> IDLE on the edge where ostream_val && ostream_rdy.
  - While ostream_rdy=0, the block stays in DONE with out stable and ostream_val held high.
- Latency: the request handshake at edge t gives ostream_val=1 from edge t + NBITS/BITS_PER_CYCLE. Default config: 8 cycles after acceptance.
- Throughput: at most one transaction in flight.
  - Minimum issue interval is NBITS/BITS_PER_CYCLE + 2 cycles (CALC cycles, one DONE cycle, one IDLE cycle).
  - istream_rdy is never high in the same cycle as ostream_val.
- out is registered. It holds the last product after DONE -> IDLE until the next completion or reset.
- istream_val while not ready: ignored, nothing latched. Inputs only need to be stable in the handshake cycle.
- Reset in CALC or DONE: the transaction is aborted and no product is emitted. The next accepted request computes correctly.
- Unsigned result is exact: max (2^NBITS-1)^2 fits in 2*NBITS bits. Signed result is exact for all inputs, including (-2^(NBITS-1))^2 = 2^(2*NBITS-2).
- istream_rdy and ostream_val are decoded from the state register only, with no combinational path from istream_val or ostream_rdy.

Decomposition:
- Shared package seq_mul_pkg:
  - state enum {IDLE, CALC, DONE}.
  - Parameter-check helper function (divisibility).
  - Localparam expression for cycle count.
- One sub-module, seq_mul_step: combinational step taking a, b, acc and producing acc_next, a_next, b_next for BITS_PER_CYCLE bits. The top-level holds the FSM, counter, sign logic and registers.

Test Plan:
- NBITS=8, K=1, unsigned, in0=255, in1=255, ostream_rdy=1 -> out=0xFE01. ostream_val rises exactly 8 cycles after acceptance. istream_rdy=0 for the whole transaction.
- Signed: in0=0x80, in1=0x80 -> out=0x4000. in0=0xFF, in1=0x7F -> out=0xFF81. in0=0xFF, in1=0x7F with is_signed=0 -> out=0x7E81.
- Backpressure: hold ostream_rdy=0 for 5 cycles in DONE -> ostream_val stays 1 and out stable. istream_val=1 during this window is not accepted. Release -> IDLE next cycle, then accept the next request.
- Assert reset mid-CALC (cycle 3), with istream_val held high -> outputs clear immediately with no clock edge needed. No ostream_val for the aborted job. Then 12*11 unsigned -> out=132.
- NBITS=8, BITS_PER_CYCLE=4: 200*3 -> out=600 with ostream_val 2 cycles after acceptance. NBITS=16, BITS_PER_CYCLE=2: 0xFFFF*0xFFFF -> 0xFFFE0001 after 8 cycles.
- Random regression: 1000 back-to-back transactions, mixed is_signed, random ostream_rdy stalls. Compare against a golden model.
